// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_seq_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   // Control-transfer opcodes (ins[6:0])
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // Sequential PC step
   localparam logic [31:0] PC_INC = 32'd4;

endpackage : pc_seq_pkg

// File: rtl/next_pc_calc.sv
// Next-PC target selection and misalignment detect for the current instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the owner decides when the target is committed.
module next_pc_calc
   import pc_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [6:0]  opcode,
   input  logic [31:0] imm,
   input  logic        branch_taken,
   input  logic [31:0] rs1_val,
   output logic [31:0] target,
   output logic        misalign
);

   logic [31:0] seq_pc;
   logic [31:0] rel_pc;
   logic [31:0] jalr_sum;

   // Candidate targets; B/J immediates are half-word offsets, hence the shift
   always_comb begin
      seq_pc   = pc + PC_INC;
      rel_pc   = pc + {imm[30:0], 1'b0};
      jalr_sum = rs1_val + imm;
   end

   // Pick the target by opcode and flag any target not on a word boundary
   always_comb begin
      target = seq_pc;
      case (opcode)
         OP_BRANCH: target = branch_taken ? rel_pc : seq_pc;
         OP_JAL:    target = rel_pc;
         OP_JALR:   target = jalr_sum & ~32'h1;
         default:   target = seq_pc;
      endcase
      misalign = |target[1:0];
   end

endmodule : next_pc_calc

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer owning the PC, instruction latch and retire counter.
// Latency: 2 cycles per instruction minimum (FETCH + EXEC), +1 per wait/stall cycle.
// Backpressure: imem_ready holds FETCH, stall holds EXEC; misaligned target halts for good.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst_n,
   // instruction memory
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   // decode / immediate generator
   output logic [31:0] ins,
   output logic        ins_valid,
   input  logic [31:0] imm,
   input  logic        branch_taken,
   input  logic [31:0] rs1_val,
   input  logic        stall,
   // status
   output logic [31:0] pc,
   output logic [31:0] link_addr,
   output logic [31:0] instret,
   output logic        halted
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ins_q, ins_d;
   logic [31:0] instret_q, instret_d;
   logic        halted_q, halted_d;

   logic [31:0] target;
   logic        misalign;

   next_pc_calc u_next_pc_calc (
      .pc           (pc_q),
      .opcode       (ins_q[6:0]),
      .imm          (imm),
      .branch_taken (branch_taken),
      .rs1_val      (rs1_val),
      .target       (target),
      .misalign     (misalign)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: FETCH waits on imem_ready, EXEC waits on stall, HALT is terminal
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (imem_ready) state_d = EXEC;
         EXEC:    if (!stall) state_d = misalign ? HALT : FETCH;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decode straight from the state register
   always_comb begin
      imem_req  = 1'b0;
      ins_valid = 1'b0;
      case (state_q)
         FETCH:   imem_req  = 1'b1;
         EXEC:    ins_valid = 1'b1;
         default: begin
            imem_req  = 1'b0;
            ins_valid = 1'b0;
         end
      endcase
   end

   // Datapath next values: latch on fetch, retire on leaving EXEC
   always_comb begin
      pc_d      = pc_q;
      ins_d     = ins_q;
      instret_d = instret_q;
      halted_d  = halted_q;
      if (state_q == FETCH && imem_ready) begin
         ins_d = imem_rdata;
      end
      if (state_q == EXEC && !stall) begin
         instret_d = instret_q + 32'd1;
         if (misalign) begin
            // pc stays on the faulting instruction for post-mortem
            halted_d = 1'b1;
         end else begin
            pc_d = target;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         ins_q     <= 32'd0;
         instret_q <= 32'd0;
         halted_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ins_q     <= ins_d;
         instret_q <= instret_d;
         halted_q  <= halted_d;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign link_addr = pc_q + PC_INC;
   assign ins       = ins_q;
   assign instret   = instret_q;
   assign halted    = halted_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
// Latency: n/a (testbench).
// Backpressure: exercises imem_ready waits and EXEC stalls.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ins;
   logic        ins_valid;
   logic [31:0] imm;
   logic        branch_taken;
   logic [31:0] rs1_val;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic [31:0] instret;
   logic        halted;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .ins          (ins),
      .ins_valid    (ins_valid),
      .imm          (imm),
      .branch_taken (branch_taken),
      .rs1_val      (rs1_val),
      .stall        (stall),
      .pc           (pc),
      .link_addr    (link_addr),
      .instret      (instret),
      .halted       (halted)
   );

   // Single comparison point for the whole bench
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample/drive 1ns after the active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // From FETCH: deliver word immediately, run EXEC without stall
   task automatic run_insn(input logic [31:0] word, input logic [31:0] imm_v,
                           input logic br, input logic [31:0] rs1);
      imem_ready = 1'b1;
      imem_rdata = word;
      step();
      imm          = imm_v;
      branch_taken = br;
      rs1_val      = rs1;
      chk("exec_valid", {31'd0, ins_valid}, 32'd1);
      chk("exec_ins", ins, word);
      step();
   endtask

   task automatic chk_reset();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, ins_valid}, 32'd0);
      chk("rst_addr", imem_addr, 32'h100);
      chk("rst_link", link_addr, 32'h104);
      chk("rst_pc", pc, 32'h100);
      chk("rst_instret", instret, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_ins", ins, 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      imem_ready   = 1'b0;
      imem_rdata   = 32'd0;
      imm          = 32'd0;
      branch_taken = 1'b0;
      rs1_val      = 32'd0;
      stall        = 1'b0;
      step();
      step();
      chk_reset();

      // Release reset: IDLE for one cycle, then FETCH
      rst_n = 1'b1;
      #1;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      step();
      chk("first_req", {31'd0, imem_req}, 32'd1);

      // Three back-to-back addi instructions with ready tied high
      imem_ready = 1'b1;
      imem_rdata = 32'h0050_0093;
      for (int i = 0; i < 3; i++) begin
         chk("seq_addr", imem_addr, 32'h100 + 32'(4 * i));
         step();
         chk("seq_valid", {31'd0, ins_valid}, 32'd1);
         chk("seq_ins", ins, 32'h0050_0093);
         step();
      end
      chk("seq_instret", instret, 32'd3);
      chk("seq_pc", pc, 32'h10C);

      // FETCH wait: ready low 3 cycles, then high
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("wait_addr", imem_addr, 32'h10C);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_valid", {31'd0, ins_valid}, 32'd0);
         step();
      end
      imem_ready = 1'b1;
      imem_rdata = 32'h0000_0013;
      chk("wait_addr_last", imem_addr, 32'h10C);
      step();
      chk("wait_exec", {31'd0, ins_valid}, 32'd1);
      chk("wait_ins", ins, 32'h0000_0013);
      step();
      chk("wait_pc", pc, 32'h110);
      chk("wait_instret", instret, 32'd4);

      // JAL 0x110 -> 0x200, then branch taken / not taken at 0x200
      run_insn(32'h0000_006F, 32'h0000_0078, 1'b0, 32'd0);
      chk("jal_to_200", pc, 32'h200);
      run_insn(32'h0000_0063, 32'hFFFF_FFF8, 1'b1, 32'd0);
      chk("br_taken_pc", pc, 32'h1F0);
      chk("br_taken_instret", instret, 32'd6);
      run_insn(32'h0000_006F, 32'h0000_0008, 1'b0, 32'd0);
      chk("jal_back_200", pc, 32'h200);
      run_insn(32'h0000_0063, 32'hFFFF_FFF8, 1'b0, 32'd0);
      chk("br_not_taken_pc", pc, 32'h204);

      // Backward JAL 0x204 -> 0x40
      run_insn(32'h0000_006F, 32'hFFFF_FF1E, 1'b0, 32'd0);
      chk("jal_to_40", pc, 32'h40);

      // JAL at 0x40, imm 0x10: link_addr during EXEC is 0x44
      imem_ready = 1'b1;
      imem_rdata = 32'h0000_006F;
      step();
      imm = 32'h10;
      chk("jal_link", link_addr, 32'h44);
      chk("jal_exec_pc", pc, 32'h40);
      step();
      chk("jal_pc", pc, 32'h60);
      chk("jal_req", {31'd0, imem_req}, 32'd1);

      // JALR clears bit 0
      run_insn(32'h0000_0067, 32'd0, 1'b0, 32'h1001);
      chk("jalr_pc", pc, 32'h1000);
      chk("jalr_instret", instret, 32'd11);

      // EXEC stall for 4 cycles
      imem_ready = 1'b1;
      imem_rdata = 32'h0000_0013;
      step();
      imm   = 32'd0;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("stall_valid", {31'd0, ins_valid}, 32'd1);
         chk("stall_pc", pc, 32'h1000);
         chk("stall_instret", instret, 32'd11);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         step();
      end
      stall = 1'b0;
      chk("stall_last_valid", {31'd0, ins_valid}, 32'd1);
      step();
      chk("unstall_pc", pc, 32'h1004);
      chk("unstall_instret", instret, 32'd12);
      chk("unstall_req", {31'd0, imem_req}, 32'd1);

      // Reset pulse in the middle of a stall aborts immediately
      step();
      stall = 1'b1;
      step();
      step();
      chk("pre_rst_valid", {31'd0, ins_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset();
      stall = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'h100);

      // Misaligned JALR target halts for good
      run_insn(32'h0000_0067, 32'd0, 1'b0, 32'h1002);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, 32'h100);
      chk("halt_instret", instret, 32'd1);
      chk("halt_valid", {31'd0, ins_valid}, 32'd0);
      imem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         step();
      end
      chk("halt_sticky", {31'd0, halted}, 32'd1);
      chk("halt_pc_final", pc, 32'h100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute sequencer that owns the program counter and drives the instruction-memory handshake. It feeds the latched instruction to the immediate generator and decode logic, then computes the next PC from that generator's immediate, the branch-compare result and rs1. It sits between instruction memory and the datapath. It replaces the free-running PC register with a handshaked, stallable controller.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  32  fetch address, equals pc
- imem_ready  in  1  instruction returned this cycle; sampled only in FETCH
- imem_rdata  in  32  returned instruction
- ins  out  32  latched instruction, to immediate generator/decode
- ins_valid  out  1  high in EXEC; ins/imm/branch_taken/rs1_val are valid
- imm  in  32  immediate from immediate generator for ins
- branch_taken  in  1  branch compare result for ins
- rs1_val  in  32  rs1 operand for JALR
- stall  in  1  datapath not done; holds EXEC
- pc  out  32  current instruction address
- link_addr  out  32  pc+4, for JAL/JALR writeback
- instret  out  32  retired-instruction counter
- halted  out  1  sticky; misaligned target taken

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE → FETCH unconditionally.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ins<=imem_rdata, then → EXEC.
  - Otherwise remain in FETCH.
- EXEC:
  - ins_valid=1.
  - stall=1: hold state, pc and ins.
  - stall=0: compute target, instret<=instret+1, pc<=target, then → FETCH.
  - If target[1:0]≠0: pc is unchanged, instret still increments, halted<=1, → HALT.
- Target select by ins[6:0]:
  - 1100011 with branch_taken=1: pc + (imm<<1). imm is a half-word offset for B and J formats.
  - 1100011 with branch_taken=0: pc+4.
  - 1101111 (JAL): pc + (imm<<1).
  - 1100111 (JALR): (rs1_val + imm) & ~32'h1.
  - All other opcodes: pc+4.
- Arithmetic is 32-bit modulo 2^32; wrap-around past 32'hFFFF_FFFC is legal. instret wraps to 0.
- HALT is terminal: imem_req=0, ins_valid=0. Exit only via rst_n.
- link_addr = pc+4, combinational from pc.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, ins=0, instret=0, halted=0.
  - imem_req=0, ins_valid=0.
  - imem_addr=RESET_PC, link_addr=RESET_PC+4.
- Asserting rst_n low mid-FETCH or mid-EXEC aborts immediately. An in-flight imem_ready is dropped.
- First imem_req occurs in the 2nd cycle after rst_n deasserts.
- Minimum 2 cycles per instruction (FETCH with immediate ready, plus EXEC without stall). Each wait cycle or stall cycle adds one.
- imem_req and ins_valid decode from the state register; they are glitch-free.
- imem_addr is stable for the whole FETCH, including wait cycles.
- stall is ignored outside EXEC. imem_ready is ignored outside FETCH.
- pc and instret update on the same edge that leaves EXEC.

## Structure
- Package pc_seq_pkg holds:
  - state enum (IDLE/FETCH/EXEC/HALT)
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
  - constant PC_INC=4
- Sub-module next_pc_calc: combinational target and misalign flag from pc, ins[6:0], imm, branch_taken, rs1_val.
- The FSM, pc, ins and instret registers stay in the top module.

## Test plan
- Reset with RESET_PC=32'h100, imem_ready tied high, 3 non-branch instructions (0x00500093):
  - imem_addr sequence 0x100, 0x104, 0x108
  - instret=3 after 6 cycles
- FETCH wait: imem_ready low 3 cycles, then high with 0x00000013:
  - imem_addr held at pc for all 4 cycles
  - EXEC follows on the next cycle
- Taken branch at pc=0x200, imm=32'hFFFF_FFF8, branch_taken=1 → next pc 0x1F0. Same with branch_taken=0 → 0x204.
- JAL at pc=0x40, imm=0x10 → pc=0x60, link_addr during EXEC = 0x44. JALR with rs1_val=0x1001, imm=0 → pc=0x1000.
- JALR with rs1_val=0x1002, imm=0:
  - halted=1, pc unchanged, state HALT
  - imem_req stays 0 for 10 cycles
- stall=1 for 4 cycles in EXEC:
  - ins_valid held
  - pc/instret unchanged until stall drops
  - rst_n pulsed low mid-stall → immediate return to reset values
